stream_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one ready/valid stream sink among `NUM_REQ` requesters, such as several producers feeding a single `Queue`/`QueuePipe` instance. It grants whole bursts: once a requester is presented on the output, the grant holds until that requester's last beat is accepted. Fairness comes from a rotating priority pointer. The payload path is combinational, with no storage and zero latency; any buffering is provided by a downstream queue.

---
 rtl/riva_utils_pkg.sv | 15 +
 rtl/stream_rr_arbiter_rr_pick.sv | 34 +++
 rtl/stream_rr_arbiter.sv | 93 +++++++++
 tb/tb_stream_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riva_utils_pkg.sv
// Shared arbitration helpers: FSM state encoding and a wrapping index increment
// that also handles non-power-of-2 requester counts.
package riva_utils_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Explicit compare so NUM_REQ need not be a power of 2.
    function automatic int unsigned rr_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr_i, with wrap.
// Purely combinational so other arbiters can reuse it.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        idx_o    = ptr_i;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any_o && req_i[cand_idx]) begin
                idx_o = cand_idx;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Burst-granting round-robin arbiter sharing one ready/valid sink among NUM_REQ
// requesters. Zero-latency combinational payload path; state is only the grant FSM.
module stream_rr_arbiter
    import riva_utils_pkg::*;
#(
    parameter  type T       = logic,
    parameter  int  NUM_REQ = 4,
    parameter  bit  LOCK_EN = 1'b1,
    localparam int  IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    input  T                   req_bits_i [NUM_REQ],
    input  logic [NUM_REQ-1:0] req_last_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output T                   out_bits_o,
    output logic               out_last_o,
    output logic [IDX_W-1:0]   out_idx_o
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] hold_idx_q, hold_idx_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [IDX_W-1:0] sel;
    logic             fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // sel depends only on valids and registered state, never on out_ready_i.
    assign sel = (state_q == HOLD) ? hold_idx_q : pick_idx;

    assign out_valid_o = req_valid_i[sel];
    assign out_bits_o  = req_bits_i[sel];
    assign out_last_o  = req_last_i[sel] | !LOCK_EN;
    assign out_idx_o   = sel;
    assign fire        = out_valid_o && out_ready_i;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready_o[gi] = out_ready_i && (sel == IDX_W'(gi));
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_idx_d = hold_idx_q;
        unique case (state_q)
            ARB: begin
                if (pick_any) begin
                    if (fire && out_last_o) begin
                        rr_ptr_d = IDX_W'(rr_inc(32'(sel), NUM_REQ));
                    end else begin
                        // Stalled beat or accepted non-last beat: pin the grant.
                        state_d    = HOLD;
                        hold_idx_d = sel;
                    end
                end
            end
            HOLD: begin
                if (fire && out_last_o) begin
                    state_d  = ARB;
                    rr_ptr_d = IDX_W'(rr_inc(32'(hold_idx_q), NUM_REQ));
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            hold_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_idx_q <= hold_idx_d;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench: 4-requester locked instance (A) and 3-requester unlocked instance (B).
module tb_stream_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: NUM_REQ=4, LOCK_EN=1, byte payload
    logic       a_rst_n;
    logic [3:0] a_valid, a_ready, a_last;
    logic [7:0] a_bits [4];
    logic       a_out_valid, a_out_ready, a_out_last;
    logic [7:0] a_out_bits;
    logic [1:0] a_out_idx;

    // Instance B: NUM_REQ=3, LOCK_EN=0, default 1-bit payload
    logic       b_rst_n;
    logic [2:0] b_valid, b_ready, b_last;
    logic       b_bits [3];
    logic       b_out_valid, b_out_ready, b_out_last;
    logic       b_out_bits;
    logic [1:0] b_out_idx;

    stream_rr_arbiter #(
        .T       (logic [7:0]),
        .NUM_REQ (4),
        .LOCK_EN (1'b1)
    ) dut_a (
        .clk_i       (clk),
        .rst_ni      (a_rst_n),
        .req_valid_i (a_valid),
        .req_ready_o (a_ready),
        .req_bits_i  (a_bits),
        .req_last_i  (a_last),
        .out_valid_o (a_out_valid),
        .out_ready_i (a_out_ready),
        .out_bits_o  (a_out_bits),
        .out_last_o  (a_out_last),
        .out_idx_o   (a_out_idx)
    );

    stream_rr_arbiter #(
        .NUM_REQ (3),
        .LOCK_EN (1'b0)
    ) dut_b (
        .clk_i       (clk),
        .rst_ni      (b_rst_n),
        .req_valid_i (b_valid),
        .req_ready_o (b_ready),
        .req_bits_i  (b_bits),
        .req_last_i  (b_last),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .out_bits_o  (b_out_bits),
        .out_last_o  (b_out_last),
        .out_idx_o   (b_out_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [3:0] v, input logic [3:0] l, input logic r);
        a_valid     = v;
        a_last      = l;
        a_out_ready = r;
        #1;
    endtask

    task automatic drive_b(input logic [2:0] v, input logic [2:0] l, input logic r);
        b_valid     = v;
        b_last      = l;
        b_out_ready = r;
        #1;
    endtask

    // One line per transaction with the observed grant.
    task automatic log_a(input string what);
        $display("[A %s] t=%0t idx=%0d valid=%0b last=%0b bits=%02h ready=%04b",
                 what, $time, a_out_idx, a_out_valid, a_out_last, a_out_bits, a_ready);
    endtask

    int cnt [4];
    int exp_seq2 [4];
    int exp_seq4 [4];
    int b_seq [4];

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_valid = '0; a_last = '0; a_out_ready = 1'b0;
        b_valid = '0; b_last = '0; b_out_ready = 1'b0;
        a_bits[0] = 8'h5A; a_bits[1] = 8'hA1; a_bits[2] = 8'h3C; a_bits[3] = 8'hE7;
        b_bits[0] = 1'b1;  b_bits[1] = 1'b0;  b_bits[2] = 1'b1;
        exp_seq2 = '{0, 2, 0, 2};
        b_seq    = '{0, 1, 2, 0};

        tick(); tick();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        #1;

        // Reset state, idle inputs
        chk("reset_out_valid", 32'(a_out_valid), 32'd0);
        chk("reset_ready",     32'(a_ready),     32'h0);
        chk("reset_idx",       32'(a_out_idx),   32'd0);

        // req0 and req2 alternate
        for (int i = 0; i < 4; i++) begin
            drive_a(4'b0101, 4'b1111, 1'b1);
            log_a("alt");
            chk("alt_idx",   32'(a_out_idx),   32'(exp_seq2[i]));
            chk("alt_valid", 32'(a_out_valid), 32'd1);
            chk("alt_bits",  32'(a_out_bits),  (exp_seq2[i] == 0) ? 32'h5A : 32'h3C);
            tick();
        end
        drive_a(4'b0000, 4'b0000, 1'b0);

        // Fresh reset, then all four single-beat for 12 cycles
        a_rst_n = 1'b0; #1; a_rst_n = 1'b1; #1;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < 12; i++) begin
            drive_a(4'b1111, 4'b1111, 1'b1);
            log_a("all");
            chk("all_idx", 32'(a_out_idx), 32'(i % 4));
            if (a_out_valid && a_out_ready) cnt[a_out_idx]++;
            tick();
        end
        for (int i = 0; i < 4; i++) chk("all_count", 32'(cnt[i]), 32'd3);

        // Advance pointer to 1 with one req0 beat
        drive_a(4'b0001, 4'b0001, 1'b1);
        log_a("prep");
        chk("prep_idx", 32'(a_out_idx), 32'd0);
        tick();

        // req1 3-beat burst with req0/req3 competing
        drive_a(4'b1011, 4'b1001, 1'b1);
        log_a("burst1");
        chk("burst_b1_idx",   32'(a_out_idx),  32'd1);
        chk("burst_b1_last",  32'(a_out_last), 32'd0);
        chk("burst_b1_ready", 32'(a_ready),    32'b0010);
        tick();
        drive_a(4'b1011, 4'b1001, 1'b1);
        log_a("burst2");
        chk("burst_b2_idx", 32'(a_out_idx), 32'd1);
        tick();
        drive_a(4'b1011, 4'b1011, 1'b1);
        log_a("burst3");
        chk("burst_b3_idx",  32'(a_out_idx),  32'd1);
        chk("burst_b3_last", 32'(a_out_last), 32'd1);
        tick();
        drive_a(4'b1001, 4'b1001, 1'b1);
        log_a("after1");
        chk("burst_next3", 32'(a_out_idx), 32'd3);
        tick();
        drive_a(4'b0001, 4'b0001, 1'b1);
        log_a("after2");
        chk("burst_next0", 32'(a_out_idx), 32'd0);
        tick();
        drive_a(4'b0000, 4'b0000, 1'b0);

        // Backpressure on req2; req0 joins in cycle 2
        for (int c = 1; c <= 5; c++) begin
            drive_a((c == 1) ? 4'b0100 : 4'b0101, 4'b0101, 1'b0);
            log_a("stall");
            chk("bp_idx",   32'(a_out_idx),   32'd2);
            chk("bp_bits",  32'(a_out_bits),  32'h3C);
            chk("bp_valid", 32'(a_out_valid), 32'd1);
            chk("bp_ready", 32'(a_ready),     32'h0);
            tick();
        end
        drive_a(4'b0101, 4'b0101, 1'b1);
        log_a("bp_fire");
        chk("bp_fire_idx",   32'(a_out_idx), 32'd2);
        chk("bp_fire_ready", 32'(a_ready),   32'b0100);
        tick();
        drive_a(4'b0001, 4'b0001, 1'b1);
        log_a("bp_next");
        chk("bp_next_idx",   32'(a_out_idx), 32'd0);
        chk("bp_next_ready", 32'(a_ready),   32'b0001);
        tick();
        drive_a(4'b0000, 4'b0000, 1'b0);

        // req3 burst with a 2-cycle valid gap; req1 waits
        drive_a(4'b1000, 4'b0000, 1'b1);
        log_a("gap_b1");
        chk("gap_b1_idx", 32'(a_out_idx), 32'd3);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive_a(4'b0010, 4'b0010, 1'b1);
            log_a("gap");
            chk("gap_valid", 32'(a_out_valid), 32'd0);
            chk("gap_idx",   32'(a_out_idx),   32'd3);
            chk("gap_ready", 32'(a_ready),     32'b1000);
            tick();
        end
        drive_a(4'b1010, 4'b1010, 1'b1);
        log_a("gap_b2");
        chk("gap_b2_idx",  32'(a_out_idx),  32'd3);
        chk("gap_b2_last", 32'(a_out_last), 32'd1);
        tick();
        drive_a(4'b0010, 4'b0010, 1'b1);
        log_a("gap_next");
        chk("gap_next_idx", 32'(a_out_idx), 32'd1);
        tick();
        drive_a(4'b0000, 4'b0000, 1'b0);

        // Unlocked 3-requester instance: rotate every beat
        for (int i = 0; i < 4; i++) begin
            drive_b(3'b111, 3'b000, 1'b1);
            $display("[B rot] t=%0t idx=%0d last=%0b ready=%03b", $time, b_out_idx, b_out_last, b_ready);
            chk("b_rot_idx",  32'(b_out_idx),  32'(b_seq[i]));
            chk("b_rot_last", 32'(b_out_last), 32'd1);
            tick();
        end
        // Pointer is now 1; reset must restart from 0
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        drive_b(3'b111, 3'b000, 1'b1);
        $display("[B rst] t=%0t idx=%0d", $time, b_out_idx);
        chk("b_after_reset_idx", 32'(b_out_idx), 32'd0);
        tick();
        drive_b(3'b111, 3'b000, 1'b1);
        $display("[B rst] t=%0t idx=%0d", $time, b_out_idx);
        chk("b_after_reset_next", 32'(b_out_idx), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
